// File: rtl/blur_stream_pkg.sv
// Shared types and constants for the 5x5 blur byte stream.
package blur_stream_pkg;

  typedef enum logic [1:0] {
    RED   = 2'd0,
    GREEN = 2'd1,
    BLUE  = 2'd2
  } color_e;

  localparam int unsigned KHEIGHT       = 5;
  localparam int unsigned BYTES_PER_COL = 15;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic logic [7:0] rgb_byte(input rgb_t px, input color_e c);
    case (c)
      RED:     return px.r;
      GREEN:   return px.g;
      default: return px.b;
    endcase
  endfunction

endpackage

// File: rtl/blur_col_streamer_if.sv
// Pixel-in / byte-out handshake bundle of blur_col_streamer.
interface blur_col_streamer_if;

  logic                  i_valid;
  logic                  o_ready;
  logic                  i_sof;
  blur_stream_pkg::rgb_t i_rgb;
  logic                  o_valid;
  logic [7:0]            o_pixel;
  logic                  o_row_end;

  modport slave (
    input  i_valid,
    input  i_sof,
    input  i_rgb,
    output o_ready,
    output o_valid,
    output o_pixel,
    output o_row_end
  );

  modport master (
    output i_valid,
    output i_sof,
    output i_rgb,
    input  o_ready,
    input  o_valid,
    input  o_pixel,
    input  o_row_end
  );

endinterface

// File: rtl/col_line_buffer.sv
// Four-row vertical-shift line buffer: reads the pre-update column, shifts it up on write.
module col_line_buffer
  import blur_stream_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = 64,
  localparam int unsigned ColW     = $clog2(IMG_WIDTH)
) (
  input  logic            i_clk,
  input  logic            i_we,
  input  logic [ColW-1:0] i_col,
  input  rgb_t            i_rgb,
  output rgb_t [3:0]      o_col
);

  // Slot 0 holds the oldest row; storage is deliberately unreset.
  rgb_t lb [4][IMG_WIDTH];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      o_col[k] = lb[k][i_col];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int k = 0; k < 3; k++) begin
        lb[k][i_col] <= lb[k+1][i_col];
      end
      lb[3][i_col] <= i_rgb;
    end
  end

endmodule

// File: rtl/blur_col_streamer.sv
// Buffers four rows and serialises each accepted pixel's 5-pixel column as R,G,B bytes.
// Macro BLUR_COL_STREAMER_EDGE_REPLICATE_EN also emits rows 0-3, replicating row 0 upward.
module blur_col_streamer
  import blur_stream_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = 64,
  parameter int unsigned KHEIGHT   = 5
) (
  input logic                i_clk,
  input logic                i_rst_n,
  blur_col_streamer_if.slave bus
);

  localparam int unsigned     ColW      = $clog2(IMG_WIDTH);
  localparam logic [ColW-1:0] LastCol   = ColW'(IMG_WIDTH - 1);
  localparam logic [2:0]      PrimedRow = 3'd4;
  localparam logic [3:0]      LastByte  = 4'(BYTES_PER_COL - 1);

  if (KHEIGHT != 5) begin : g_kheight_check
    $error("blur_col_streamer: KHEIGHT must be 5");
  end

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e                        state_q;
  logic [ColW-1:0]               col_q;
  logic [2:0]                    row_q;
  logic [3:0]                    byte_idx_q;
  logic [BYTES_PER_COL-1:0][7:0] hold_q;
  logic                          hold_last_q;
  logic                          o_valid_q;
  logic [7:0]                    o_pixel_q;
  logic                          o_row_end_q;

  logic                          ready;
  logic                          accept;
  logic                          primed;
  logic                          last_col;
  logic [ColW-1:0]               eff_col;
  logic [ColW-1:0]               next_col;
  logic [2:0]                    eff_row;
  logic [2:0]                    next_row;
  rgb_t [3:0]                    lb_col;
  rgb_t [4:0]                    col_px;
  logic [BYTES_PER_COL-1:0][7:0] col_bytes;

  assign ready         = (state_q == StIdle) || (byte_idx_q == LastByte);
  assign accept        = bus.i_valid && ready;
  assign bus.o_ready   = ready;
  assign bus.o_valid   = o_valid_q;
  assign bus.o_pixel   = o_pixel_q;
  assign bus.o_row_end = o_row_end_q;

  col_line_buffer #(
    .IMG_WIDTH(IMG_WIDTH)
  ) u_line_buffer (
    .i_clk(i_clk),
    .i_we (accept),
    .i_col(eff_col),
    .i_rgb(bus.i_rgb),
    .o_col(lb_col)
  );

  always_comb begin
    // SOF relocates the accepted pixel to (row 0, col 0).
    eff_col  = bus.i_sof ? '0 : col_q;
    eff_row  = bus.i_sof ? '0 : row_q;
    last_col = (eff_col == LastCol);
    next_col = last_col ? '0 : eff_col + 1'b1;
    next_row = (last_col && (eff_row != PrimedRow)) ? eff_row + 3'd1 : eff_row;

    col_px[4] = bus.i_rgb;
    for (int k = 0; k < 4; k++) begin
      col_px[k] = lb_col[k];
    end
`ifdef BLUR_COL_STREAMER_EDGE_REPLICATE_EN
    primed = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k < 4 - int'(eff_row)) begin
        col_px[k] = (eff_row == '0) ? bus.i_rgb : lb_col[2'(PrimedRow - eff_row)];
      end
    end
`else
    primed = (eff_row == PrimedRow);
`endif

    for (int k = 0; k < 5; k++) begin
      col_bytes[3*k]   = rgb_byte(col_px[k], RED);
      col_bytes[3*k+1] = rgb_byte(col_px[k], GREEN);
      col_bytes[3*k+2] = rgb_byte(col_px[k], BLUE);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      byte_idx_q  <= '0;
      hold_q      <= '0;
      hold_last_q <= 1'b0;
      o_valid_q   <= 1'b0;
      o_pixel_q   <= '0;
      o_row_end_q <= 1'b0;
    end else begin
      if (accept) begin
        col_q <= next_col;
        row_q <= next_row;
      end

      // o_pixel always shows hold byte[byte_idx]; byte 0 is taken straight from the new column.
      if (accept && primed) begin
        state_q     <= StEmit;
        byte_idx_q  <= '0;
        hold_q      <= col_bytes;
        hold_last_q <= last_col;
        o_valid_q   <= 1'b1;
        o_pixel_q   <= col_bytes[0];
        o_row_end_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            byte_idx_q <= '0;
          end
          StEmit: begin
            if (byte_idx_q == LastByte) begin
              state_q     <= StIdle;
              byte_idx_q  <= '0;
              o_valid_q   <= 1'b0;
              o_pixel_q   <= '0;
              o_row_end_q <= 1'b0;
            end else begin
              byte_idx_q  <= byte_idx_q + 4'd1;
              o_pixel_q   <= hold_q[byte_idx_q + 4'd1];
              o_row_end_q <= hold_last_q && (byte_idx_q == LastByte - 4'd1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
